// File: rtl/clint_pkg.sv
// Shared CLINT definitions: data width, register window offsets and the offset decoder.
package clint_pkg;

   localparam int unsigned CLINT_XLEN      = 32;
   localparam logic [31:0] CLINT_BASE_ADDR = 32'h0200_0000;

   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   localparam logic [63:0] MTIMECMP_RESET = '1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_MTIMECMP_LO,
      REG_MTIMECMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI
   } reg_sel_t;

   // Takes the word index (byte offset bits 15:2); the byte lane bits never matter.
   function automatic reg_sel_t decode_offset(input logic [13:0] word);
      reg_sel_t sel;
      case (word)
         CLINT_MSIP[15:2]:        sel = REG_MSIP;
         CLINT_MTIMECMP_LO[15:2]: sel = REG_MTIMECMP_LO;
         CLINT_MTIMECMP_HI[15:2]: sel = REG_MTIMECMP_HI;
         CLINT_MTIME_LO[15:2]:    sel = REG_MTIME_LO;
         CLINT_MTIME_HI[15:2]:    sel = REG_MTIME_HI;
         default:                 sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick_o for one cycle on the last count.
module clint_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

   logic [15:0] count;

   assign tick_o = (count == LAST);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count <= '0;
      end else if (tick_o) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip, mtime and mtimecmp with timer/software interrupts.
module clint
   import clint_pkg::*;
#(
   parameter int unsigned       XLEN      = CLINT_XLEN,
   parameter logic [XLEN-1:0]   BASE_ADDR = XLEN'(CLINT_BASE_ADDR),
   parameter int unsigned       TICK_DIV  = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata_o,
   output logic            sel_o,
   output logic            timer_irq_o,
   output logic            software_irq_o
);

   logic        hit;
   logic        wr;
   logic        rd;
   reg_sel_t    reg_sel;
   logic        tick;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [31:0] rd_word;
   logic        unused_addr;

   assign unused_addr = ^addr_i[1:0];

   assign hit = req_i && (addr_i[XLEN-1:16] == BASE_ADDR[XLEN-1:16]);
   assign wr  = hit && we_i;
   assign rd  = hit && !we_i;

   always_comb begin
      reg_sel = REG_NONE;
      if (hit) begin
         reg_sel = decode_offset(addr_i[15:2]);
      end
   end

   clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   // A bus write to either half wins over the tick; the increment for that cycle is dropped.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mtime <= '0;
      end else if (wr && reg_sel == REG_MTIME_LO) begin
         mtime[31:0] <= wdata_i[31:0];
      end else if (wr && reg_sel == REG_MTIME_HI) begin
         mtime[63:32] <= wdata_i[31:0];
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mtimecmp <= MTIMECMP_RESET;
      end else if (wr && reg_sel == REG_MTIMECMP_LO) begin
         mtimecmp[31:0] <= wdata_i[31:0];
      end else if (wr && reg_sel == REG_MTIMECMP_HI) begin
         mtimecmp[63:32] <= wdata_i[31:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         msip <= 1'b0;
      end else if (wr && reg_sel == REG_MSIP) begin
         msip <= wdata_i[0];
      end
   end

   always_comb begin
      rd_word = '0;
      case (reg_sel)
         REG_MSIP:        rd_word = {31'b0, msip};
         REG_MTIMECMP_LO: rd_word = mtimecmp[31:0];
         REG_MTIMECMP_HI: rd_word = mtimecmp[63:32];
         REG_MTIME_LO:    rd_word = mtime[31:0];
         REG_MTIME_HI:    rd_word = mtime[63:32];
         default:         rd_word = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata_o     <= '0;
         sel_o       <= 1'b0;
         timer_irq_o <= 1'b0;
      end else begin
         rdata_o     <= rd ? XLEN'(rd_word) : '0;
         sel_o       <= hit;
         timer_irq_o <= (mtime >= mtimecmp);
      end
   end

   assign software_irq_o = msip;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: a TICK_DIV=1 and a TICK_DIV=4 instance driven with directed vectors.
module tb_clint;

   localparam logic [31:0] BASE        = 32'h0200_0000;
   localparam logic [31:0] A_MSIP      = BASE + 32'h0000;
   localparam logic [31:0] A_MTCMP_LO  = BASE + 32'h4000;
   localparam logic [31:0] A_MTCMP_HI  = BASE + 32'h4004;
   localparam logic [31:0] A_MTIME_LO  = BASE + 32'hBFF8;
   localparam logic [31:0] A_MTIME_HI  = BASE + 32'hBFFC;
   localparam logic [31:0] ONES        = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst   [2] = '{1'b1, 1'b1};
   logic        req   [2] = '{1'b0, 1'b0};
   logic        we    [2] = '{1'b0, 1'b0};
   logic [31:0] addr  [2] = '{32'h0, 32'h0};
   logic [31:0] wdata [2] = '{32'h0, 32'h0};
   logic [31:0] rdata [2];
   logic        sel   [2];
   logic        tirq  [2];
   logic        sirq  [2];
   logic        rd_pend [2] = '{1'b0, 1'b0};

   int checks = 0;
   int errors = 0;

   // read entries: {dut, sel, data}; probe entries: {dut, bus, sel, tirq, sirq, data}
   logic [33:0] rd_q[$];
   string       rd_n[$];
   logic [36:0] pr_q[$];
   string       pr_n[$];

   always #5 clk = ~clk;

   clint #(.XLEN(32), .BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
      .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .rdata_o(rdata[0]), .sel_o(sel[0]),
      .timer_irq_o(tirq[0]), .software_irq_o(sirq[0]));

   clint #(.XLEN(32), .BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
      .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .rdata_o(rdata[1]), .sel_o(sel[1]),
      .timer_irq_o(tirq[1]), .software_irq_o(sirq[1]));

   always @(posedge clk) begin
      rd_pend[0] <= req[0] && !we[0];
      rd_pend[1] <= req[1] && !we[1];
   end

   function automatic void cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      end
   endfunction

   // Monitor: pops a read expectation whenever a DUT presents a read response, then drains probes.
   always @(negedge clk) begin
      logic [33:0] e;
      logic [36:0] p;
      string       n;
      for (int d = 0; d < 2; d++) begin
         if (rd_pend[d]) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL read_underflow: dut %0d responded, expected no pending read", d);
            end else begin
               e = rd_q.pop_front();
               n = rd_n.pop_front();
               cmp({n, "_dut"}, 32'(d), 32'(e[33]));
               cmp({n, "_sel"}, 32'(sel[d]), 32'(e[32]));
               cmp({n, "_rdata"}, rdata[d], e[31:0]);
            end
         end
      end
      while (pr_q.size() > 0) begin
         p = pr_q.pop_front();
         n = pr_n.pop_front();
         cmp({n, "_timer_irq"}, 32'(tirq[p[36]]), 32'(p[33]));
         cmp({n, "_software_irq"}, 32'(sirq[p[36]]), 32'(p[32]));
         if (p[35]) begin
            cmp({n, "_sel"}, 32'(sel[p[36]]), 32'(p[34]));
            cmp({n, "_rdata"}, rdata[p[36]], p[31:0]);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
      req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = v;
      @(posedge clk);
      #1;
      req[d] = 1'b0; we[d] = 1'b0;
   endtask

   task automatic rd(input int d, input logic [31:0] a, input logic s, input logic [31:0] e,
                     input string n);
      req[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
      rd_q.push_back({1'(d), s, e});
      rd_n.push_back(n);
      @(posedge clk);
      #1;
      req[d] = 1'b0;
   endtask

   task automatic probe(input int d, input logic bus, input logic s, input logic t,
                        input logic w, input logic [31:0] e, input string n);
      pr_q.push_back({1'(d), bus, s, t, w, e});
      pr_n.push_back(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      probe(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset_d1");
      probe(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset_d4");
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b1;

      // TICK_DIV=1: mtime equals the number of edges since release
      idle(10);
      rd(0, A_MTIME_LO, 1'b1, 32'd10, "mtime_lo_idle10");
      rd(0, A_MTIME_HI, 1'b1, 32'd0, "mtime_hi_idle10");
      rd(0, A_MTCMP_LO, 1'b1, ONES, "mtimecmp_lo_reset");
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "irq_idle");

      wr(0, A_MTCMP_HI, 32'd0);
      wr(0, A_MTCMP_LO, 32'd20);
      idle(4);
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "tirq_mtime19");
      idle(1);
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "tirq_mtime20");
      idle(1);
      probe(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "tirq_rise");
      rd(0, A_MTIME_LO, 1'b1, 32'd21, "mtime_lo_21");
      wr(0, A_MTCMP_LO, ONES);
      probe(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "tirq_hold");
      idle(1);
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "tirq_drop");

      wr(0, A_MSIP, ONES);
      probe(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "msip_set");
      rd(0, A_MSIP, 1'b1, 32'd1, "msip_read");
      wr(0, A_MSIP, 32'd0);
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "msip_clear");
      wr(0, BASE + 32'h1000, 32'hDEAD_BEEF);
      rd(0, BASE + 32'h1000, 1'b1, 32'd0, "unmapped_read");
      rd(0, 32'h1000_0000, 1'b0, 32'd0, "window_miss");
      rd(0, A_MTCMP_LO, 1'b1, ONES, "unmapped_write_dropped");
      rd(0, BASE + 32'hBFFF, 1'b1, 32'd0, "byte_lane_ignored");

      // 64-bit carry and wrap
      wr(0, A_MTIME_LO, 32'hFFFF_FFFE);
      wr(0, A_MTIME_HI, 32'd0);
      idle(2);
      rd(0, A_MTIME_LO, 1'b1, 32'd0, "carry_lo");
      rd(0, A_MTIME_HI, 1'b1, 32'd1, "carry_hi");
      wr(0, A_MTIME_LO, ONES);
      rd(0, A_MTIME_HI, 1'b1, 32'd1, "lo_write_no_carry");
      wr(0, A_MTIME_LO, ONES);
      wr(0, A_MTIME_HI, ONES);
      idle(1);
      probe(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "tirq_before_wrap");
      rd(0, A_MTIME_LO, 1'b1, 32'd0, "wrap_lo");
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "tirq_wrap_clear");
      rd(0, A_MTIME_HI, 1'b1, 32'd0, "wrap_hi");

      // asynchronous reset while both interrupts are up and a read is in flight
      wr(0, A_MTCMP_LO, 32'd0);
      wr(0, A_MSIP, 32'd1);
      probe(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, "irqs_before_reset");
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = A_MTIME_LO;
      rd_q.push_back({1'b0, 1'b0, 32'd0});
      rd_n.push_back("inflight_read_reset");
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      #1;
      rst[0] = 1'b0;
      probe(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "async_reset_outputs");
      idle(1);
      probe(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset_held");
      rst[0] = 1'b1;
      rd(0, A_MTCMP_LO, 1'b1, ONES, "mtimecmp_lo_after_reset");
      rd(0, A_MTCMP_HI, 1'b1, ONES, "mtimecmp_hi_after_reset");
      rd(0, A_MSIP, 1'b1, 32'd0, "msip_after_reset");
      rd(0, A_MTIME_LO, 1'b1, 32'd3, "mtime_after_reset");
      probe(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "irqs_after_reset");

      // TICK_DIV=4: ticks are consumed on edges 4, 8, 12, ... after release
      rst[1] = 1'b1;
      idle(3);
      wr(1, A_MTIME_LO, 32'd5);
      rd(1, A_MTIME_LO, 1'b1, 32'd5, "d4_write_in_tick");
      idle(2);
      rd(1, A_MTIME_LO, 1'b1, 32'd5, "d4_before_tick");
      rd(1, A_MTIME_LO, 1'b1, 32'd6, "d4_after_tick");
      idle(2);
      wr(1, A_MTIME_HI, 32'd7);
      rd(1, A_MTIME_LO, 1'b1, 32'd6, "d4_hi_write_lo_kept");
      rd(1, A_MTIME_HI, 1'b1, 32'd7, "d4_hi_write");
      wr(1, A_MTCMP_LO, 32'd100);
      rd(1, A_MTIME_LO, 1'b1, 32'd6, "d4_cmp_write_pre_tick");
      rd(1, A_MTIME_LO, 1'b1, 32'd7, "d4_cmp_write_no_prescaler_reset");

      idle(3);
      cmp("scoreboard_drained", 32'(rd_q.size() + pr_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
